// File: rtl/md5_compress_iter.sv
// Iterative MD5 compression of one 512-bit block, STEPS_PER_CYCLE rounds per clock,
// with feed-forward of the chaining value and valid/ready handshakes on both sides.
module md5_compress_iter #(
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] block,
  input  logic [127:0] chain_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] digest,
  output logic         busy
);

  localparam int S = STEPS_PER_CYCLE;

  if (!(S == 1 || S == 2 || S == 4 || S == 8 || S == 16)) begin : g_bad_steps
    $error("md5_compress_iter: STEPS_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  localparam logic [5:0] STEP_INC   = 6'(S);
  localparam logic [5:0] LAST_GROUP = 6'(64 - S);

  localparam logic [31:0] K_TAB [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  // Rotate amounts indexed by {round, step mod 4}.
  localparam logic [4:0] S_TAB [16] = '{
    5'd7, 5'd12, 5'd17, 5'd22,
    5'd5, 5'd9,  5'd14, 5'd20,
    5'd4, 5'd11, 5'd16, 5'd23,
    5'd6, 5'd10, 5'd15, 5'd21
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FINAL,
    ST_DONE
  } state_e;

  // Field order matches the chain_in packing, so a plain cast loads A..D.
  typedef struct packed {
    logic [31:0] d;
    logic [31:0] c;
    logic [31:0] b;
    logic [31:0] a;
  } work_t;

  function automatic work_t md5_step(input work_t w, input logic [5:0] i,
                                     input logic [511:0] m);
    logic [31:0] f;
    logic [31:0] t;
    logic [63:0] dbl;
    logic [3:0]  lo;
    logic [3:0]  g;
    work_t       r;
    lo = i[3:0];
    unique case (i[5:4])
      2'd0: begin
        f = (w.b & w.c) | (~w.b & w.d);
        g = lo;
      end
      2'd1: begin
        f = (w.b & w.d) | (w.c & ~w.d);
        g = lo * 4'd5 + 4'd1;
      end
      2'd2: begin
        f = w.b ^ w.c ^ w.d;
        g = lo * 4'd3 + 4'd5;
      end
      default: begin
        f = w.c ^ (w.b | ~w.d);
        g = lo * 4'd7;
      end
    endcase
    t   = w.a + f + K_TAB[i] + m[{g, 5'd0} +: 32];
    // Upper half of the doubled word shifted left is the left rotation.
    dbl = {t, t} << S_TAB[{i[5:4], i[1:0]}];
    r.a = w.d;
    r.b = w.b + dbl[63:32];
    r.c = w.b;
    r.d = w.c;
    return r;
  endfunction

  state_e       state_q, state_d;
  logic [5:0]   step_q, step_d;
  logic [511:0] blk_q, blk_d;
  work_t        chain_q, chain_d;
  work_t        work_q, work_d;
  logic [127:0] digest_q, digest_d;
  work_t        work_nx;

  // NOTE: blocking assignments are correct here; the variable is rewritten per
  // unrolled step so each step sees the previous step's result within one cycle.
  always_comb begin
    work_t w;
    w = work_q;
    for (int j = 0; j < S; j++) begin
      w = md5_step(w, step_q + 6'(j), blk_q);
    end
    work_nx = w;
  end

  // NOTE: every _d gets its hold value first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    blk_d    = blk_q;
    chain_d  = chain_q;
    work_d   = work_q;
    digest_d = digest_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          blk_d   = block;
          chain_d = work_t'(chain_in);
          work_d  = work_t'(chain_in);
          step_d  = 6'd0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        work_d = work_nx;
        step_d = step_q + STEP_INC;
        if (step_q == LAST_GROUP) begin
          state_d = ST_FINAL;
        end
      end
      ST_FINAL: begin
        digest_d = {chain_q.d + work_q.d, chain_q.c + work_q.c,
                    chain_q.b + work_q.b, chain_q.a + work_q.a};
        state_d  = ST_DONE;
      end
      default: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // NOTE: non-blocking assignments for all state so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      step_q   <= 6'd0;
      blk_q    <= '0;
      chain_q  <= '0;
      work_q   <= '0;
      digest_q <= '0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      blk_q    <= blk_d;
      chain_q  <= chain_d;
      work_q   <= work_d;
      digest_q <= digest_d;
    end
  end

  // in_ready must stay low while reset is held even though the state reads IDLE.
  assign in_ready  = rst_n && (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_RUN) || (state_q == ST_FINAL);
  assign digest    = digest_q;

endmodule

// File: tb/tb_md5_compress_iter.sv
// Self-checking bench for md5_compress_iter: five instances (S=1..16) share stimulus;
// results are compared with known MD5 vectors and a sine-derived reference model.
module tb_md5_compress_iter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [511:0] blk = '0;
  logic [127:0] chain = '0;
  logic [4:0]   ir_all;
  logic [4:0]   ov_all;
  logic [4:0]   busy_all;
  logic [127:0] dg_all [5];

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  int unsigned k_tab [64];
  int s_tab [4][4] = '{'{7, 12, 17, 22}, '{5, 9, 14, 20}, '{4, 11, 16, 23}, '{6, 10, 15, 21}};

  localparam logic [127:0] IV        = {32'h10325476, 32'h98badcfe, 32'hefcdab89, 32'h67452301};
  localparam logic [127:0] EXP_EMPTY = {32'h7e42f8ec, 32'h980980e9, 32'h04b2008f, 32'hd98c1dd4};
  localparam logic [127:0] EXP_ABC   = {32'h727fe128, 32'h7d3f96d6, 32'hb04fd23c, 32'h98500190};
  localparam logic [127:0] EXP_A64   = {32'h67733f79, 32'h63034a5a, 32'h4971b580, 32'hd4424801};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar k = 0; k < 5; k++) begin : g_dut
    md5_compress_iter #(.STEPS_PER_CYCLE(1 << k)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (ir_all[k]),
      .block    (blk),
      .chain_in (chain),
      .out_valid(ov_all[k]),
      .out_ready(out_ready),
      .digest   (dg_all[k]),
      .busy     (busy_all[k])
    );
  end

  function automatic logic [127:0] md5_model(input logic [511:0] m, input logic [127:0] ch);
    logic [31:0] a, b, c, d, f, t, tmp;
    int g, s;
    a = ch[31:0]; b = ch[63:32]; c = ch[95:64]; d = ch[127:96];
    for (int i = 0; i < 64; i++) begin
      if (i < 16)      begin f = (b & c) | (~b & d); g = i;                end
      else if (i < 32) begin f = (b & d) | (c & ~d); g = (5 * i + 1) % 16; end
      else if (i < 48) begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
      else             begin f = c ^ (b | ~d);       g = (7 * i) % 16;     end
      t   = a + f + k_tab[i] + m[32 * g +: 32];
      s   = s_tab[i / 16][i % 4];
      tmp = d; d = c; c = b;
      b   = b + ((t << s) | (t >> (32 - s)));
      a   = tmp;
    end
    return {ch[127:96] + d, ch[95:64] + c, ch[63:32] + b, ch[31:0] + a};
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32 * i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Waits (bounded) for dut 0 out_valid; n = cycles after the accept edge, or -1.
  task automatic wait_out(input int max_cyc, output int n);
    n = -1;
    for (int c = 1; c <= max_cyc && n < 0; c++) begin
      @(posedge clk); #1;
      if (ov_all[0]) n = c;
    end
  endtask

  task automatic accept(input logic [511:0] b, input logic [127:0] ch, output int acc_cyc);
    int n;
    n = 0;
    while (!ir_all[0] && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    blk = b; chain = ch; in_valid = 1'b1;
    @(posedge clk); #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    in_valid = 1'b0; out_ready = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (ir_all[k] !== 1'b0 || ov_all[k] !== 1'b0 || busy_all[k] !== 1'b0 || dg_all[k] !== '0) begin
        errors++;
        $display("FAIL reset_state S=%0d: in_ready=%b out_valid=%b busy=%b digest=%h, need 0/0/0/0",
                 1 << k, ir_all[k], ov_all[k], busy_all[k], dg_all[k]);
      end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ir_all !== 5'b11111 || busy_all !== 5'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b busy=%b, need 11111/00000", ir_all, busy_all);
    end
  endtask

  // One block through all five instances with out_ready low; checks latency and digest.
  task automatic run_on_all(input logic [511:0] b, input logic [127:0] ch,
                            input logic [127:0] exp, input string name);
    int seen [5];
    int acc;
    for (int k = 0; k < 5; k++) seen[k] = -1;
    out_ready = 1'b0;
    accept(b, ch, acc);
    checks++;
    if (busy_all !== 5'b11111 || ir_all !== 5'b0) begin
      errors++;
      $display("FAIL %s_busy_after_accept: busy=%b in_ready=%b, need 11111/00000", name, busy_all, ir_all);
    end
    for (int c = 1; c <= 80; c++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 5; k++) if (ov_all[k] && seen[k] < 0) seen[k] = c;
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (seen[k] != 64 / (1 << k) + 1) begin
        errors++;
        $display("FAIL %s_latency S=%0d: got %0d cycles, need %0d", name, 1 << k, seen[k], 64 / (1 << k) + 1);
      end
      checks++;
      if (dg_all[k] !== exp) begin
        errors++;
        $display("FAIL %s_digest S=%0d: got %h, need %h", name, 1 << k, dg_all[k], exp);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (ir_all !== 5'b11111 || ov_all !== 5'b0) begin
      errors++;
      $display("FAIL %s_return_idle: in_ready=%b out_valid=%b, need 11111/00000", name, ir_all, ov_all);
    end
  endtask

  task automatic test_vectors();
    logic [511:0] b;
    b = '0; b[31:0] = 32'h00000080;
    run_on_all(b, IV, EXP_EMPTY, "empty");
    b = '0; b[31:0] = 32'h80636261; b[14 * 32 +: 32] = 32'h00000018;
    run_on_all(b, IV, EXP_ABC, "abc");
  endtask

  task automatic test_hold();
    logic [511:0] b;
    int acc, n;
    b = '0; b[31:0] = 32'h80636261; b[14 * 32 +: 32] = 32'h00000018;
    out_ready = 1'b0;
    accept(b, IV, acc);
    wait_out(100, n);
    checks++;
    if (n != 65) begin
      errors++;
      $display("FAIL hold_latency: got %0d, need 65", n);
    end
    for (int c = 0; c < 20; c++) begin
      in_valid = $urandom_range(0, 1);
      blk      = rand512();
      chain    = rand128();
      @(posedge clk); #1;
      checks++;
      if (dg_all[0] !== EXP_ABC || ir_all[0] !== 1'b0 || ov_all[0] !== 1'b1) begin
        errors++;
        $display("FAIL hold_cycle%0d: digest=%h in_ready=%b out_valid=%b, need %h/0/1",
                 c, dg_all[0], ir_all[0], ov_all[0], EXP_ABC);
      end
    end
    // Output handshake with in_valid high: must go to IDLE without accepting.
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (ir_all[0] !== 1'b1 || ov_all[0] !== 1'b0 || busy_all[0] !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: in_ready=%b out_valid=%b busy=%b, need 1/0/0",
               ir_all[0], ov_all[0], busy_all[0]);
    end
    // out_ready while idle has no effect and nothing was accepted.
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (ir_all[0] !== 1'b1 || busy_all[0] !== 1'b0 || dg_all[0] !== EXP_ABC) begin
      errors++;
      $display("FAIL idle_out_ready: in_ready=%b busy=%b digest=%h, need 1/0/%h",
               ir_all[0], busy_all[0], dg_all[0], EXP_ABC);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [511:0] b;
    int acc, n;
    b = '0; b[31:0] = 32'h80636261; b[14 * 32 +: 32] = 32'h00000018;
    accept(rand512(), rand128(), acc);
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (ov_all[0] !== 1'b0 || dg_all[0] !== '0 || busy_all[0] !== 1'b0 || ir_all[0] !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset: out_valid=%b digest=%h busy=%b in_ready=%b, need 0/0/0/0",
               ov_all[0], dg_all[0], busy_all[0], ir_all[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ir_all[0] !== 1'b1 || ov_all[0] !== 1'b0) begin
      errors++;
      $display("FAIL midrun_release: in_ready=%b out_valid=%b, need 1/0", ir_all[0], ov_all[0]);
    end
    // Re-run abc while in_valid and block are disturbed during RUN.
    accept(b, IV, acc);
    n = -1;
    for (int c = 1; c <= 100 && n < 0; c++) begin
      in_valid = $urandom_range(0, 1);
      blk      = rand512();
      chain    = rand128();
      @(posedge clk); #1;
      if (ov_all[0]) n = c;
    end
    in_valid = 1'b0;
    checks++;
    if (n != 65 || dg_all[0] !== EXP_ABC) begin
      errors++;
      $display("FAIL midrun_rerun: latency=%0d digest=%h, need 65/%h", n, dg_all[0], EXP_ABC);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [511:0] b;
    logic [127:0] ch, exp;
    int acc, prev_acc, n;
    do_reset();
    out_ready = 1'b1;
    prev_acc  = 0;
    for (int it = 0; it < 6; it++) begin
      b   = rand512();
      ch  = rand128();
      exp = md5_model(b, ch);
      accept(b, ch, acc);
      if (it > 0) begin
        checks++;
        if (acc - prev_acc != 67) begin
          errors++;
          $display("FAIL b2b_interval it%0d: got %0d cycles, need 67", it, acc - prev_acc);
        end
      end
      prev_acc = acc;
      wait_out(100, n);
      checks++;
      if (n != 65 || dg_all[0] !== exp) begin
        errors++;
        $display("FAIL b2b_digest it%0d: latency=%0d digest=%h, need 65/%h", it, n, dg_all[0], exp);
      end
    end
    out_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_two_block();
    logic [511:0] b1, b2;
    logic [127:0] mid;
    int acc, n;
    do_reset();
    for (int i = 0; i < 16; i++) b1[32 * i +: 32] = 32'h61616161;
    b2 = '0; b2[31:0] = 32'h00000080; b2[14 * 32 +: 32] = 32'h00000200;
    accept(b1, IV, acc);
    wait_out(100, n);
    mid = dg_all[0];
    checks++;
    if (n != 65 || mid !== md5_model(b1, IV)) begin
      errors++;
      $display("FAIL chain_block1: latency=%0d digest=%h, need 65/%h", n, mid, md5_model(b1, IV));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    do_reset();
    run_on_all(b2, mid, EXP_A64, "chain_block2");
  endtask

  initial begin
    real r;
    for (int i = 0; i < 64; i++) begin
      r = $sin(real'(i + 1));
      if (r < 0.0) r = -r;
      k_tab[i] = 32'(longint'($floor(r * 4294967296.0)));
    end
    test_reset();
    test_vectors();
    test_hold();
    test_reset_mid_run();
    test_back_to_back();
    test_two_block();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/md5_compress_iter.md
Name: md5_compress_iter

Overview:
- Full 64-step MD5 compression function for one 512-bit block, including the final feed-forward add of the chaining value.
- Parametrised by the number of steps unrolled per clock, so the area/latency trade-off is set at instantiation.
- Valid/ready handshakes on input and output let a padding/length front-end and a multi-block chaining controller stream blocks through it.

Parameters:
- STEPS_PER_CYCLE, 1, MD5 steps evaluated combinationally per clock. Legal values: 1, 2, 4, 8, 16. Any other value is a compile-time error.

Ports:
- clk  input  1  clock. All state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  block and chain_in are valid.
- in_ready  output  1  block accepted when in_valid && in_ready.
- block  input  512  message block. Word M[i] = block[32*i+31:32*i]; words are little-endian, so byte 0 of the block is block[7:0].
- chain_in  input  128  input chaining value: [31:0]=A, [63:32]=B, [95:64]=C, [127:96]=D.
- out_valid  output  1  digest valid.
- out_ready  input  1  downstream accepts the digest.
- digest  output  128  output chaining value, same packing as chain_in. Each word is chain_in word + final working word, mod 2^32.
- busy  output  1  high in RUN and FINAL.

Behaviour:
- States: IDLE, RUN, FINAL, DONE.
- Reset (asynchronous, any state): state=IDLE; in_ready=0 while rst_n is low; out_valid=0, busy=0, digest=0, step counter=0, all internal registers=0.
- IDLE:
  - in_ready=1.
  - On handshake: latch block and chain_in; load working a,b,c,d from chain_in; step=0; go to RUN.
- RUN:
  - Each cycle, apply STEPS_PER_CYCLE consecutive steps i = step .. step+S-1.
  - step += S (6-bit counter). Once the last group (i=63) completes, go to FINAL.
  - RUN therefore lasts exactly 64/S cycles.
- Step i, all arithmetic mod 2^32:
  - f: i<16 F=(b&c)|(~b&d); i<32 G=(b&d)|(c&~d); i<48 H=b^c^d; else I=c^(b|~d).
  - g: i<16 i; i<32 (5i+1)%16; i<48 (3i+5)%16; else (7i)%16.
  - K[i] = floor(|sin(i+1)|*2^32), held in a constant table.
  - Rotate amount s by round, cycling through 4 values: round0 7,12,17,22; round1 5,9,14,20; round2 4,11,16,23; round3 6,10,15,21.
  - Update: t=a+f+K[i]+M[g]; (a,b,c,d) <= (d, b+rotl(t,s), b, c).
- FINAL (1 cycle): digest <= {D+d, C+c, B+b, A+a}; go to DONE.
- DONE:
  - out_valid=1; digest held stable.
  - On out_ready, go to IDLE next cycle.
  - No new block is accepted in the same cycle as the output handshake.
- Latency: out_valid rises 64/S+1 cycles after the edge that accepts the input. Back-to-back throughput is one block per 64/S+3 cycles when out_ready is held high.
- in_ready=0 in RUN, FINAL and DONE. in_valid pulses in those states are ignored, and the latched block/chain_in must not change.
- out_ready asserted outside DONE has no effect.
- busy=1 in RUN and FINAL; busy=0 in IDLE and DONE.
- Reset asserted mid-RUN: the computation is aborted with no output. After release the block is in IDLE with in_ready=1.
- No combinational path from in_valid/out_ready to any output other than through state.

Test Plan:
- Empty string: block word0=0x00000080, all other words 0; chain_in=IV {D=10325476, C=98badcfe, B=efcdab89, A=67452301} -> digest A=d98c1dd4, B=04b2008f, C=980980e9, D=7e42f8ec (bytes d41d8cd98f00b204e9800998ecf8427e).
- "abc": word0=0x80636261, word14=0x00000018, other words 0, IV -> A=98500190, B=b04fd23c, C=7d3f96d6, D=727fe128 (bytes 900150983cd24fb0d6963f7d28e17f72).
- Run both vectors at S=1,2,4,8,16 -> identical digests; out_valid exactly 65, 33, 17, 9, 5 cycles after the accept edge.
- Hold out_ready=0 for 20 cycles in DONE while toggling in_valid -> digest stable, in_ready=0; then out_ready=1 -> IDLE next cycle, in_ready=1.
- Assert rst_n=0 at RUN step 30 -> out_valid=0, digest=0, busy=0 immediately. Re-run "abc" -> correct digest.
- Two-block chain: feed the digest of a 64-byte "a"x64 first block as chain_in for its padding block -> matches the reference MD5 of 64 'a's (014842d480b571495a4a0363793f7367).
